// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one instruction-memory
// read in flight over a valid/ready request + valid response interface, and
// presents each fetched word with its address to decode. A downstream stall holds
// the presented word. An execute redirect retargets the fetch stream. A misaligned
// redirect parks the unit in a sticky fault state until reset.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        memReqValid,
    output logic [31:0] memReqAddr,
    input  logic        memReqReady,
    input  logic        memRespValid,
    input  logic [31:0] memRespData,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        instrValid,
    output logic        fetchFault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_pc_s;
    logic        discard_r;      // the in-flight response belongs to a stale stream
    logic        discard_s;
    logic        fault_r;
    logic        fault_s;
    logic        latch_s;        // capture memRespData into the presented word
    logic [31:0] instr_r;
    logic [31:0] pc_r;
    logic        req_valid_r;
    logic        req_valid_s;
    logic        instr_valid_r;
    logic        instr_valid_s;

    // Instruction addresses must sit on a 4-byte boundary.
    function automatic logic is_aligned(input logic [31:0] addr);
        is_aligned = (addr[1:0] == 2'b00);
    endfunction

    // State and datapath registers; outputs are registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= RESET_PC;
            discard_r     <= 1'b0;
            fault_r       <= 1'b0;
            instr_r       <= 32'h0000_0000;
            pc_r          <= 32'h0000_0000;
            req_valid_r   <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            fetch_pc_r    <= fetch_pc_s;
            discard_r     <= discard_s;
            fault_r       <= fault_s;
            req_valid_r   <= req_valid_s;
            instr_valid_r <= instr_valid_s;
            if (latch_s) begin
                instr_r <= memRespData;
                pc_r    <= fetch_pc_r;
            end else begin
                instr_r <= instr_r;
                pc_r    <= pc_r;
            end
        end
    end

    // Next-state logic: fault and redirect take priority over normal sequencing.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        discard_s  = discard_r;
        fault_s    = fault_r;
        latch_s    = 1'b0;
        if (state_r == ST_FAULT) begin
            // Everything is ignored until reset; any outstanding response is lost.
            state_s = ST_FAULT;
        end else if (redirectValid && !is_aligned(redirectPc)) begin
            state_s   = ST_FAULT;
            fault_s   = 1'b1;
            discard_s = 1'b0;
        end else if (redirectValid) begin
            fetch_pc_s = redirectPc;
            case (state_r)
                ST_REQ: begin
                    if (memReqReady) begin
                        // The old address was accepted this cycle; its data is stale.
                        state_s   = ST_WAIT;
                        discard_s = 1'b1;
                    end else begin
                        state_s   = ST_REQ;
                        discard_s = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (memRespValid) begin
                        // Stale response arrives now: drop it and refetch.
                        state_s   = ST_REQ;
                        discard_s = 1'b0;
                    end else begin
                        state_s   = ST_WAIT;
                        discard_s = 1'b1;
                    end
                end
                default: begin
                    // IDLE and HOLD: any held word is abandoned.
                    state_s   = ST_REQ;
                    discard_s = 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_REQ;
                end
                ST_REQ: begin
                    if (memReqReady) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (memRespValid && discard_r) begin
                        state_s   = ST_REQ;
                        discard_s = 1'b0;
                    end else if (memRespValid) begin
                        state_s = ST_HOLD;
                        latch_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        // Word consumed; advance sequentially (wraps at 2^32).
                        state_s    = ST_REQ;
                        fetch_pc_s = fetch_pc_r + PC_STEP;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_FAULT;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
        req_valid_s   = 1'b0;
        instr_valid_s = 1'b0;
        case (state_s)
            ST_REQ:  req_valid_s   = 1'b1;
            ST_HOLD: instr_valid_s = 1'b1;
            default: begin
                req_valid_s   = 1'b0;
                instr_valid_s = 1'b0;
            end
        endcase
    end

    assign memReqValid = req_valid_r;
    assign memReqAddr  = fetch_pc_r;
    assign instruction = instr_r;
    assign pc          = pc_r;
    assign instrValid  = instr_valid_r;
    assign fetchFault  = fault_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural single-outstanding
// memory whose response latency is adjustable per request.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc = 32'h0000_0000;
    logic        memReqValid;
    logic [31:0] memReqAddr;
    logic        memReqReady = 1'b1;
    logic        memRespValid = 1'b0;
    logic [31:0] memRespData = 32'h0000_0000;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instrValid;
    logic        fetchFault;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int resp_lat = 1;

    instruction_fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .redirectValid(redirectValid),
        .redirectPc   (redirectPc),
        .memReqValid  (memReqValid),
        .memReqAddr   (memReqAddr),
        .memReqReady  (memReqReady),
        .memRespValid (memRespValid),
        .memRespData  (memRespData),
        .instruction  (instruction),
        .pc           (pc),
        .instrValid   (instrValid),
        .fetchFault   (fetchFault)
    );

    always #5 clock = ~clock;

    // Memory contents: one known RISC-V word at 0x4, an address pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0004) mem_word = 32'h0031_0133;
        else                       mem_word = addr ^ 32'hA5A5_0000;
    endfunction

    // Memory model: samples the handshake at the edge, answers after resp_lat cycles.
    logic        pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr = 32'h0000_0000;
    always @(posedge clock) begin
        logic        acc;
        logic [31:0] a;
        logic        rst_seen;
        acc      = memReqValid & memReqReady;
        a        = memReqAddr;
        rst_seen = reset;
        cyc      = cyc + 1;
        #1;
        memRespValid = 1'b0;
        if (rst_seen) begin
            pend = 1'b0;
        end else begin
            if (acc) begin
                pend  = 1'b1;
                cnt   = resp_lat;
                paddr = a;
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    memRespValid = 1'b1;
                    memRespData  = mem_word(paddr);
                    pend         = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_reqvalid", {31'd0, memReqValid}, 32'd0);
        check_eq("rst_reqaddr",  memReqAddr,           32'h0000_0000);
        check_eq("rst_ivalid",   {31'd0, instrValid},  32'd0);
        check_eq("rst_fault",    {31'd0, fetchFault},  32'd0);
        check_eq("rst_instr",    instruction,          32'h0000_0000);
        check_eq("rst_pc",       pc,                   32'h0000_0000);
        reset = 1'b0;
    endtask

    // Waits for a request at the given address (bounded).
    task automatic wait_req(input string tag, input logic [31:0] addr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (memReqValid) found = 1'b1;
        end
        check_eq({tag, "_seen"}, {31'd0, found}, 32'd1);
        if (found) check_eq({tag, "_addr"}, memReqAddr, addr);
    endtask

    // Waits for the next presented instruction and checks pc and data (bounded).
    task automatic wait_instr(input string tag, input logic [31:0] exp_pc, output int at_cyc);
        logic found;
        found  = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (instrValid) found = 1'b1;
        end
        at_cyc = cyc;
        check_eq({tag, "_seen"}, {31'd0, found}, 32'd1);
        if (found) begin
            check_eq({tag, "_pc"},    pc,          exp_pc);
            check_eq({tag, "_instr"}, instruction, mem_word(exp_pc));
        end
    endtask

    initial begin
        int t0, t1, t2;

        // 1: sequential fetch 0x0, 0x4, 0x8, one instruction every 3 cycles
        do_reset();
        @(negedge clock);
        check_eq("t1_first_req", {31'd0, memReqValid}, 32'd1);
        check_eq("t1_first_addr", memReqAddr, 32'h0000_0000);
        wait_instr("t1_i0", 32'h0000_0000, t0);
        wait_req("t1_r4", 32'h0000_0004);
        wait_instr("t1_i4", 32'h0000_0004, t1);
        wait_req("t1_r8", 32'h0000_0008);
        wait_instr("t1_i8", 32'h0000_0008, t2);
        check_eq("t1_rate_a", t1 - t0, 32'd3);
        check_eq("t1_rate_b", t2 - t1, 32'd3);

        // 2: stall five cycles in HOLD on pc 0x4
        do_reset();
        wait_instr("t2_i0", 32'h0000_0000, t0);
        wait_instr("t2_i4", 32'h0000_0004, t0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("t2_hold_valid", {31'd0, instrValid}, 32'd1);
            check_eq("t2_hold_pc", pc, 32'h0000_0004);
            check_eq("t2_hold_instr", instruction, 32'h0031_0133);
            check_eq("t2_hold_noreq", {31'd0, memReqValid}, 32'd0);
        end
        stall = 1'b0;
        wait_req("t2_r8", 32'h0000_0008);

        // 3: redirect to 0x100 while waiting on 0x8, slow response dropped
        resp_lat = 3;
        @(negedge clock);
        check_eq("t3_in_wait", {31'd0, memReqValid}, 32'd0);
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0100;
        @(negedge clock);
        redirectValid = 1'b0;
        resp_lat      = 1;
        wait_req("t3_r100", 32'h0000_0100);
        wait_instr("t3_i100", 32'h0000_0100, t0);

        // 4: redirect to 0x200 in the same cycle the held word is consumed
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0200;
        @(negedge clock);
        redirectValid = 1'b0;
        check_eq("t4_drop_valid", {31'd0, instrValid}, 32'd0);
        check_eq("t4_req", {31'd0, memReqValid}, 32'd1);
        check_eq("t4_addr", memReqAddr, 32'h0000_0200);
        wait_instr("t4_i200", 32'h0000_0200, t0);

        // 5: memory not ready; request retargeted to 0x40 while pending
        memReqReady = 1'b0;
        do_reset();
        @(negedge clock);
        check_eq("t5_c1_addr", memReqAddr, 32'h0000_0000);
        @(negedge clock);
        check_eq("t5_c2_req", {31'd0, memReqValid}, 32'd1);
        check_eq("t5_c2_addr", memReqAddr, 32'h0000_0000);
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0040;
        @(negedge clock);
        redirectValid = 1'b0;
        check_eq("t5_c3_req", {31'd0, memReqValid}, 32'd1);
        check_eq("t5_c3_addr", memReqAddr, 32'h0000_0040);
        memReqReady = 1'b1;
        @(negedge clock);
        check_eq("t5_accepted", {31'd0, memReqValid}, 32'd0);
        wait_instr("t5_i40", 32'h0000_0040, t0);

        // 5b: redirect in the cycle the old request is accepted
        wait_req("t5_r44", 32'h0000_0044);
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0080;
        @(negedge clock);
        redirectValid = 1'b0;
        check_eq("t5b_wait", {31'd0, memReqValid}, 32'd0);
        wait_req("t5b_r80", 32'h0000_0080);
        wait_instr("t5b_i80", 32'h0000_0080, t0);

        // 6: misaligned redirect faults; reset recovers; PC wraps past 0xFFFFFFFC
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0102;
        @(negedge clock);
        check_eq("t6_fault", {31'd0, fetchFault}, 32'd1);
        check_eq("t6_ivalid", {31'd0, instrValid}, 32'd0);
        check_eq("t6_noreq", {31'd0, memReqValid}, 32'd0);
        redirectPc = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("t6_parked_req", {31'd0, memReqValid}, 32'd0);
            check_eq("t6_parked_fault", {31'd0, fetchFault}, 32'd1);
        end
        redirectValid = 1'b0;
        do_reset();
        wait_req("t6_restart", 32'h0000_0000);
        redirectValid = 1'b1;
        redirectPc    = 32'hFFFF_FFFC;
        @(negedge clock);
        redirectValid = 1'b0;
        wait_req("t6_rtop", 32'hFFFF_FFFC);
        wait_instr("t6_itop", 32'hFFFF_FFFC, t0);
        wait_req("t6_rwrap", 32'h0000_0000);
        wait_instr("t6_iwrap", 32'h0000_0000, t0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
